// File: rtl/alu_result_stage.sv
// Registered ALU result stage: captures LO/HI results with zero/negative flags into a
// 2-entry skid buffer (head + skid) so the ALU can keep issuing while the bus side stalls.
module alu_result_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_lo,
    input  logic [DATA_W-1:0] in_hi,
    input  logic              in_wide,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] z_lo,
    output logic [DATA_W-1:0] z_hi,
    output logic              flag_zero,
    output logic              flag_neg,
    output logic [1:0]        occupancy,
    output logic [1:0]        state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // in_ready depends only on state (and clear); out_valid only on state. A producer
    // holding valid keeps its data stable until the transfer completes.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
        logic              zero;
        logic              neg;
    } entry_t;

    state_t state, state_nxt;
    entry_t head, skid, cap;
    logic   push, pop;
    logic   load_head_new, load_head_skid, load_skid;
    logic [DATA_W-1:0] cap_hi;

    // Flags are fixed when the result is captured, not recomputed downstream.
    assign cap_hi   = in_wide ? in_hi : '0;
    assign cap.lo   = in_lo;
    assign cap.hi   = cap_hi;
    assign cap.zero = (in_lo == '0) && (cap_hi == '0);
    assign cap.neg  = in_wide ? in_hi[DATA_W-1] : in_lo[DATA_W-1];

    assign in_ready  = !clear && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign z_lo      = head.lo;
    assign z_hi      = head.hi;
    assign flag_zero = head.zero;
    assign flag_neg  = head.neg;
    assign occupancy = state;
    assign state_dbg = state;

    always_comb begin
        state_nxt      = state;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt     = ONE;
                    load_head_new = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (pop && !push) begin
                    state_nxt = EMPTY;
                end else if (push && pop) begin
                    load_head_new = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_nxt;
            if (load_head_new) begin
                head <= cap;
            end else if (load_head_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= cap;
            end
        end
    end

endmodule
